wb_split: RTL and testbench

- Parametrised single-master, N-slave pipelined Wishbone B4 splitter with address decode, outstanding-transaction tracking, unmapped-address error and bus timeout.
- Successor to the fixed-NS crossbar use in the SoC top. Adds compile-time slave count, per-slave address/mask tables, error generation and fault recovery.
- Sits between picorv32_wb and the peripheral slaves (ROM, RAMs, GPIO, UART, measure unit) in the wb_clk_i domain.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_split_if.sv | 43 ++++
 rtl/wb_addr_decode.sv | 31 +++
 rtl/wb_split.sv | 133 +++++++++++++
 tb/tb_wb_split.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and width helpers for the wishbone splitter
package wb_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  localparam int NS_MAX = 16;
  typedef logic [$clog2(NS_MAX)-1:0] slave_idx_t;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_split_if.sv
// rtl/wb_split_if.sv - master-side and slave-side wishbone signals of the splitter
interface wb_split_if #(
  parameter int NS = 6,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic               wbm_cyc_i;
  logic               wbm_stb_i;
  logic               wbm_we_i;
  logic [AW-1:0]      wbm_adr_i;
  logic [DW-1:0]      wbm_dat_i;
  logic [DW/8-1:0]    wbm_sel_i;
  logic               wbm_ack_o;
  logic               wbm_err_o;
  logic               wbm_stall_o;
  logic [DW-1:0]      wbm_dat_o;
  logic [NS-1:0]      wbs_cyc_o;
  logic [NS-1:0]      wbs_stb_o;
  logic [NS-1:0]      wbs_we_o;
  logic [NS*AW-1:0]   wbs_adr_o;
  logic [NS*DW-1:0]   wbs_dat_o;
  logic [NS*DW/8-1:0] wbs_sel_o;
  logic [NS-1:0]      wbs_ack_i;
  logic [NS-1:0]      wbs_err_i;
  logic [NS-1:0]      wbs_stall_i;
  logic [NS*DW-1:0]   wbs_dat_i;

  // The splitter's own view.
  modport slave (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i,
    input  wbs_ack_i, wbs_err_i, wbs_stall_i, wbs_dat_i,
    output wbm_ack_o, wbm_err_o, wbm_stall_o, wbm_dat_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o
  );

  // The surrounding bus master plus peripherals.
  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i,
    output wbs_ack_i, wbs_err_i, wbs_stall_i, wbs_dat_i,
    input  wbm_ack_o, wbm_err_o, wbm_stall_o, wbm_dat_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o
  );
endinterface

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - address/mask table decode with lowest-index priority
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int             NS         = 6,
  parameter int             AW         = 32,
  parameter logic [NS*AW-1:0] SLAVE_ADDR = '0,
  parameter logic [NS*AW-1:0] SLAVE_MASK = '0
) (
  input  logic [AW-1:0] adr,
  output logic [NS-1:0] hit_onehot,
  output slave_idx_t    idx,
  output logic          mapped
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit_onehot = '0;
    idx        = '0;
    mapped     = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((adr & SLAVE_MASK[i*AW +: AW]) == SLAVE_ADDR[i*AW +: AW]) begin
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
        idx           = slave_idx_t'(i);
        mapped        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_split.sv
// rtl/wb_split.sv - single-master, N-slave pipelined wishbone splitter with error and timeout
module wb_split
  import wb_pkg::*;
#(
  parameter int               NS              = 6,
  parameter int               AW              = 32,
  parameter int               DW              = 32,
  parameter logic [NS*AW-1:0] SLAVE_ADDR      = '0,
  parameter logic [NS*AW-1:0] SLAVE_MASK      = '0,
  parameter int               MAX_OUTSTANDING = 4,
  parameter int               TIMEOUT_CYCLES  = 1024
) (
  input  logic      wb_clk_i,
  input  logic      wb_rst_i,
  wb_split_if.slave bus,
  output logic      timeout_o
);

  localparam int CW = cnt_w(MAX_OUTSTANDING);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);

  state_t          state_q, state_d;
  logic [CW-1:0]   out_q, out_d;
  slave_idx_t      target_q, target_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [NS-1:0]   dec_onehot;
  slave_idx_t      dec_idx;
  logic            dec_mapped;
  logic            sel_stall, tgt_ack, tgt_err;
  logic [DW-1:0]   tgt_dat;
  logic            busy, full, resp, tmo_fire, stall_int, accept, keep_active;

  wb_addr_decode #(
    .NS(NS), .AW(AW), .SLAVE_ADDR(SLAVE_ADDR), .SLAVE_MASK(SLAVE_MASK)
  ) u_decode (
    .adr(bus.wbm_adr_i), .hit_onehot(dec_onehot), .idx(dec_idx), .mapped(dec_mapped)
  );

  always_comb begin
    sel_stall = 1'b0;
    tgt_ack   = 1'b0;
    tgt_err   = 1'b0;
    tgt_dat   = '0;
    for (int i = 0; i < NS; i++) begin
      if (dec_idx == slave_idx_t'(i)) sel_stall = bus.wbs_stall_i[i];
      if (target_q == slave_idx_t'(i)) begin
        tgt_ack = bus.wbs_ack_i[i];
        tgt_err = bus.wbs_err_i[i];
        tgt_dat = bus.wbs_dat_i[i*DW +: DW];
      end
    end
  end

  assign busy     = (out_q != '0);
  assign full     = (out_q == CW'(MAX_OUTSTANDING));
  assign resp     = bus.wbm_cyc_i & busy & (tgt_ack | tgt_err);
  assign tmo_fire = (TIMEOUT_CYCLES != 0) && bus.wbm_cyc_i && (state_q == ACTIVE) && !resp &&
                    (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // The abort cycle also stalls so no request is swallowed while the cycle drops.
  assign stall_int = (busy & dec_mapped & (dec_idx != target_q)) | full |
                     (dec_mapped & sel_stall) | (~dec_mapped & busy) |
                     (state_q == ERR) | tmo_fire;
  assign accept      = bus.wbm_cyc_i & bus.wbm_stb_i & ~stall_int;
  assign keep_active = (state_q == ACTIVE) & ~tmo_fire;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      bus.wbs_cyc_o[i] = wb_rst_i & bus.wbm_cyc_i &
                         ((keep_active & (target_q == slave_idx_t'(i))) | (accept & dec_onehot[i]));
    end
  end

  assign bus.wbs_stb_o   = {NS{wb_rst_i & bus.wbm_cyc_i & bus.wbm_stb_i & ~stall_int}} & dec_onehot;
  assign bus.wbs_we_o    = {NS{bus.wbm_we_i}};
  assign bus.wbs_adr_o   = {NS{bus.wbm_adr_i}};
  assign bus.wbs_dat_o   = {NS{bus.wbm_dat_i}};
  assign bus.wbs_sel_o   = {NS{bus.wbm_sel_i}};
  assign bus.wbm_stall_o = wb_rst_i & stall_int;
  assign bus.wbm_ack_o   = wb_rst_i & bus.wbm_cyc_i & busy & tgt_ack;
  assign bus.wbm_err_o   = wb_rst_i & ((bus.wbm_cyc_i & busy & tgt_err) | (state_q == ERR) | tmo_fire);
  assign bus.wbm_dat_o   = wb_rst_i ? tgt_dat : '0;
  assign timeout_o       = wb_rst_i & tmo_fire;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    target_d = target_q;
    timer_d  = '0;
    if (!bus.wbm_cyc_i || tmo_fire) begin
      state_d = IDLE;
      out_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (dec_mapped) begin
              state_d  = ACTIVE;
              target_d = dec_idx;
              out_d    = CW'(1);
            end else begin
              state_d = ERR;
            end
          end
        end
        ACTIVE: begin
          if (accept && !resp) out_d = out_q + CW'(1);
          else if (resp && !accept) out_d = out_q - CW'(1);
          if (out_d == '0) state_d = IDLE;
          if (!resp && !accept) timer_d = timer_q + TW'(1);
        end
        ERR:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= IDLE;
      out_q    <= '0;
      target_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      target_q <= target_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: tb/tb_wb_split.sv
// tb/tb_wb_split.sv - directed vector and sequence bench for wb_split
module tb_wb_split;

  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn;
  logic timeout;
  int   checks = 0;
  int   failures = 0;

  logic [NS-1:0]    ack_man = '0;
  logic [NS*DW-1:0] dat_man = '0;
  logic             s0_en = 1'b0;
  logic             mon_en = 1'b0;
  logic [3:0]       dly_v = '0;
  logic [31:0]      dly_a [4];
  int               ack_cnt = 0;
  logic [31:0]      ack_dat [8];

  always #5 clk = ~clk;

  wb_split_if #(.NS(NS), .AW(AW), .DW(DW)) bus ();

  wb_split #(
    .NS(NS), .AW(AW), .DW(DW),
    .SLAVE_ADDR({32'h0200_0000, 32'h0100_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hffff_ffc0, 32'hff00_0000, 32'hff00_0000}),
    .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rstn), .bus(bus), .timeout_o(timeout)
  );

  // Slave0 model: acks each accepted strobe four edges later, returning its address.
  always @(posedge clk) begin
    if (!s0_en) dly_v <= '0;
    else dly_v <= {dly_v[2:0], bus.wbs_stb_o[0]};
    dly_a[0] <= bus.wbs_adr_o[31:0];
    dly_a[1] <= dly_a[0];
    dly_a[2] <= dly_a[1];
    dly_a[3] <= dly_a[2];
  end

  assign bus.wbs_ack_i = ack_man | {2'b00, s0_en & dly_v[3]};
  assign bus.wbs_dat_i = s0_en ? {dat_man[95:32], dly_a[3]} : dat_man;

  always @(negedge clk) begin
    if (!mon_en) ack_cnt <= 0;
    else if (bus.wbm_ack_o && ack_cnt < 8) begin
      ack_dat[ack_cnt] <= bus.wbm_dat_o;
      ack_cnt <= ack_cnt + 1;
    end
  end

  typedef struct packed {
    logic [31:0] adr;
    logic [2:0]  stall_in;
    logic [2:0]  ack_in;
    logic [2:0]  stb_exp;
    logic        stall_exp;
    logic [2:0]  cyc_exp;
    logic        ack_exp;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    ack_man = '0;
    bus.wbs_stall_i = '0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic first_st [6];
    int   n, tmo_at, tmo_cnt;
    logic cyc_ok, err_at_tmo, cyc_at_tmo;

    vt[0] = '{32'h0100_0010, 3'b000, 3'b000, 3'b010, 1'b0, 3'b010, 1'b0};
    vt[1] = '{32'h0000_0004, 3'b000, 3'b111, 3'b001, 1'b0, 3'b001, 1'b0};
    vt[2] = '{32'h0200_003c, 3'b000, 3'b000, 3'b100, 1'b0, 3'b100, 1'b0};
    vt[3] = '{32'h0200_0040, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0};
    vt[4] = '{32'h0100_0010, 3'b010, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0};
    vt[5] = '{32'h0100_0010, 3'b001, 3'b000, 3'b010, 1'b0, 3'b010, 1'b0};
    vt[6] = '{32'h0300_0000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0};
    vt[7] = '{32'h00ff_fffc, 3'b100, 3'b000, 3'b001, 1'b0, 3'b001, 1'b0};

    bus.wbm_we_i = 1'b0;
    bus.wbm_dat_i = 32'h1234_5678;
    bus.wbm_sel_i = 4'hf;
    bus.wbs_err_i = '0;
    bus.wbs_stall_i = '0;
    bus.wbm_adr_i = 32'h0100_0010;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    ack_man = 3'b111;
    dat_man = {96{1'b1}};
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("reset_ctl", {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_stall_o, timeout}, 0);
    chk("reset_dat", bus.wbm_dat_o, 0);
    ack_man = '0;
    dat_man = '0;
    idle_bus();
    step();
    rstn = 1'b1;
    step();

    // combinational decode/strobe vectors in IDLE, withdrawn before each edge
    for (int i = 0; i < 8; i++) begin
      bus.wbm_adr_i = vt[i].adr;
      bus.wbs_stall_i = vt[i].stall_in;
      ack_man = vt[i].ack_in;
      bus.wbm_cyc_i = 1'b1;
      bus.wbm_stb_i = 1'b1;
      #2;
      chk($sformatf("vec%0d", i), {bus.wbs_stb_o, bus.wbm_stall_o, bus.wbs_cyc_o, bus.wbm_ack_o},
          {vt[i].stb_exp, vt[i].stall_exp, vt[i].cyc_exp, vt[i].ack_exp});
      bus.wbm_stb_i = 1'b0;
      ack_man = '0;
      bus.wbs_stall_i = '0;
      step();
    end
    idle_bus();

    // single read to slave1
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_adr_i = 32'h0100_0010;
    @(negedge clk);
    chk("s1_stb", bus.wbs_stb_o, 3'b010);
    step();
    bus.wbm_stb_i = 1'b0; ack_man = 3'b010; dat_man[63:32] = 32'hcafe_babe;
    @(negedge clk);
    chk("s1_ack", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbs_cyc_o}, {1'b1, 1'b0, 3'b010});
    chk("s1_dat", bus.wbm_dat_o, 32'hcafe_babe);
    step();
    ack_man = '0;
    @(negedge clk);
    chk("s1_idle", {bus.wbs_cyc_o, bus.wbm_ack_o}, 0);
    idle_bus();

    // six pipelined reads to slave0 with delayed acks
    s0_en = 1'b1; mon_en = 1'b1; bus.wbm_cyc_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.wbm_adr_i = 32'(k * 4);
      bus.wbm_stb_i = 1'b1;
      n = 0;
      @(negedge clk);
      first_st[k] = bus.wbm_stall_o;
      while (bus.wbm_stall_o && n < 20) begin
        step();
        n++;
        @(negedge clk);
      end
      step();
    end
    bus.wbm_stb_i = 1'b0;
    n = 0;
    while (ack_cnt < 6 && n < 30) begin
      step();
      n++;
    end
    chk("p_nostall", {first_st[0], first_st[1], first_st[2], first_st[3]}, 4'b0000);
    chk("p_stall5", first_st[4], 1'b1);
    chk("p_ackcnt", ack_cnt, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("p_dat%0d", i), ack_dat[i], 32'(i * 4));
    @(negedge clk);
    chk("p_idle", bus.wbs_cyc_o, 3'b000);
    s0_en = 1'b0; mon_en = 1'b0;
    idle_bus();

    // unmapped read
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_adr_i = 32'h0200_0040;
    @(negedge clk);
    chk("u_stb", {bus.wbs_stb_o, bus.wbm_err_o}, 4'b0000);
    step();
    bus.wbm_stb_i = 1'b0;
    @(negedge clk);
    chk("u_err", {bus.wbm_err_o, bus.wbs_cyc_o}, {1'b1, 3'b000});
    step();
    @(negedge clk);
    chk("u_err_off", bus.wbm_err_o, 1'b0);
    idle_bus();

    // back-to-back target switch waits for slave0's ack
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_adr_i = 32'h0000_0000;
    step();
    bus.wbm_adr_i = 32'h0200_0000;
    @(negedge clk);
    chk("b_stall", {bus.wbm_stall_o, bus.wbs_stb_o}, {1'b1, 3'b000});
    step();
    step();
    ack_man = 3'b001; dat_man[31:0] = 32'h1111_2222;
    @(negedge clk);
    chk("b_ack0", {bus.wbm_ack_o, bus.wbm_stall_o, bus.wbm_dat_o}, {1'b1, 1'b1, 32'h1111_2222});
    step();
    ack_man = '0;
    @(negedge clk);
    chk("b_issue2", {bus.wbm_stall_o, bus.wbs_stb_o}, {1'b0, 3'b100});
    step();
    bus.wbm_stb_i = 1'b0; ack_man = 3'b100; dat_man[95:64] = 32'haaaa_5555;
    @(negedge clk);
    chk("b_ack2", {bus.wbm_ack_o, bus.wbm_dat_o}, {1'b1, 32'haaaa_5555});
    step();
    idle_bus();

    // timeout on slave1
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_adr_i = 32'h0100_0020;
    step();
    bus.wbm_stb_i = 1'b0;
    tmo_at = 0; tmo_cnt = 0; cyc_ok = 1'b1; err_at_tmo = 1'b0; cyc_at_tmo = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (timeout) tmo_cnt++;
      if (timeout && tmo_at == 0) begin
        tmo_at = c;
        err_at_tmo = bus.wbm_err_o;
        cyc_at_tmo = bus.wbs_cyc_o[1];
      end else if (tmo_at == 0 && !bus.wbs_cyc_o[1]) begin
        cyc_ok = 1'b0;
      end
      step();
    end
    chk("t_cycle", tmo_at, 16);
    chk("t_pulse", {tmo_cnt[3:0], err_at_tmo, cyc_at_tmo, cyc_ok}, {4'd1, 1'b1, 1'b0, 1'b1});
    ack_man = 3'b010;
    #2;
    chk("t_stray", {bus.wbm_ack_o, bus.wbs_cyc_o}, 0);
    idle_bus();

    // reset while two reads are outstanding
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_adr_i = 32'h0000_0000;
    step();
    bus.wbm_adr_i = 32'h0000_0004;
    step();
    rstn = 1'b0; ack_man = 3'b001; dat_man[31:0] = 32'hdead_beef;
    #1;
    chk("r_ctl", {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_stall_o, timeout}, 0);
    chk("r_dat", bus.wbm_dat_o, 0);
    idle_bus();
    step();
    rstn = 1'b1;
    step();
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_adr_i = 32'h0000_0008;
    @(negedge clk);
    chk("r_stb", {bus.wbs_stb_o, bus.wbm_stall_o}, {3'b001, 1'b0});
    step();
    bus.wbm_stb_i = 1'b0; ack_man = 3'b001; dat_man[31:0] = 32'h1234_abcd;
    @(negedge clk);
    chk("r_ack", {bus.wbm_ack_o, bus.wbm_dat_o}, {1'b1, 32'h1234_abcd});
    step();
    ack_man = '0;
    @(negedge clk);
    chk("r_idle", {bus.wbs_cyc_o, bus.wbm_ack_o}, 0);
    idle_bus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
